md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS datapath, placed beside the single-cycle arithmetic unit in the EX stage. It performs signed/unsigned 32x32 multiply and 32/32 divide and holds results in HI/LO. It raises `busy` while computing so the hazard unit stalls later multiply/divide and HI/LO-reading instructions. Multiply uses a latency counter; divide is an iterative restoring divider.

---
 rtl/md_unit.sv | 201 ++++++++++++++++++++
 tb/tb_md_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit holding results in HI/LO.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops.
module md_unit #(
  parameter int unsigned MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t        state, state_nx;
  logic [3:0]    op, op_nx;
  logic [W-1:0]  op_a, op_a_nx, op_b, op_b_nx, quo, quo_nx, rem, rem_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          neg_q, neg_q_nx, neg_r, neg_r_nx;
  logic [W-1:0]  hi_nx, lo_nx;
  logic          done_nx;

  logic           launch_mul_c, launch_div_c, mul_signed_c, take_c;
  logic [2*W-1:0] a_ext_c, b_ext_c, prod_c, mul_res_c;
  logic [W-1:0]   divisor_c, rem_step_c, quo_step_c, q_fix_c, r_fix_c;
  logic [W:0]     shifted_c;

  // Launch decode: only sampled while idle, so a start during busy is dropped.
  always_comb begin
    launch_mul_c = 1'b0;
    launch_div_c = 1'b0;
    if (state == S_IDLE && start) begin
      case (MDOp)
        OP_MULT, OP_MULTU: launch_mul_c = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch_mul_c = 1'b1;
`endif
        OP_DIV, OP_DIVU: launch_div_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Product and accumulate against HI/LO as held at completion.
  always_comb begin
    mul_signed_c = (op == OP_MULT);
`ifdef MDU_MADD_EN
    mul_signed_c = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`endif
    a_ext_c   = mul_signed_c ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
    b_ext_c   = mul_signed_c ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
    prod_c    = a_ext_c * b_ext_c;
    mul_res_c = prod_c;
`ifdef MDU_MADD_EN
    case (op)
      OP_MADD, OP_MADDU: mul_res_c = {HI, LO} + prod_c;
      OP_MSUB, OP_MSUBU: mul_res_c = {HI, LO} - prod_c;
      default: ;
    endcase
`endif
  end

  // One restoring step per cycle: quotient bits shift in at the bottom of quo.
  always_comb begin
    divisor_c  = (op == OP_DIV && op_b[W-1]) ? -op_b : op_b;
    shifted_c  = {rem, quo[W-1]};
    take_c     = shifted_c >= {1'b0, divisor_c};
    rem_step_c = take_c ? W'(shifted_c - {1'b0, divisor_c}) : shifted_c[W-1:0];
    quo_step_c = {quo[W-2:0], take_c};
    q_fix_c    = neg_q ? -quo : quo;
    r_fix_c    = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      op_a  <= op_a_nx;
      op_b  <= op_b_nx;
      quo   <= quo_nx;
      rem   <= rem_nx;
      cnt   <= cnt_nx;
      neg_q <= neg_q_nx;
      neg_r <= neg_r_nx;
      HI    <= hi_nx;
      LO    <= lo_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (launch_mul_c)      state_nx = S_MUL;
        else if (launch_div_c) state_nx = S_DIV;
      end
      S_MUL:   if (cnt == CW'(1)) state_nx = S_IDLE;
      S_DIV:   if (cnt == CW'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and HI/LO update; HI/LO change only on completion or mthi/mtlo.
  always_comb begin
    op_nx    = op;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    quo_nx   = quo;
    rem_nx   = rem;
    cnt_nx   = cnt;
    neg_q_nx = neg_q;
    neg_r_nx = neg_r;
    hi_nx    = HI;
    lo_nx    = LO;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch_mul_c) begin
          op_nx   = MDOp;
          op_a_nx = A;
          op_b_nx = B;
          cnt_nx  = CW'(MULT_LAT);
        end else if (launch_div_c) begin
          op_nx    = MDOp;
          op_a_nx  = A;
          op_b_nx  = B;
          quo_nx   = (MDOp == OP_DIV && A[W-1]) ? -A : A;
          rem_nx   = '0;
          neg_q_nx = (MDOp == OP_DIV) && (A[W-1] ^ B[W-1]);
          neg_r_nx = (MDOp == OP_DIV) && A[W-1];
          cnt_nx   = CW'(W);
        end else if (start && MDOp == OP_MTHI) begin
          hi_nx = A;
        end else if (start && MDOp == OP_MTLO) begin
          lo_nx = A;
        end
      end
      S_MUL: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          {hi_nx, lo_nx} = mul_res_c;
          done_nx        = 1'b1;
        end
      end
      S_DIV: begin
        cnt_nx = cnt - CW'(1);
        quo_nx = quo_step_c;
        rem_nx = rem_step_c;
      end
      S_FIX: begin
        cnt_nx  = '0;
        done_nx = 1'b1;
        if (op_b == '0) begin
          lo_nx = '1;
          hi_nx = op_a;
        end else begin
          lo_nx = q_fix_c;
          hi_nx = r_fix_c;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply, divide, corner cases, ignored starts and reset abort.
module tb_md_unit;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  md_unit #(.MULT_LAT(5)) dut (
    .clk(clk), .reset(rst_n), .start(start), .MDOp(mdop), .A(a), .B(b),
    .busy(busy), .done(done), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] opa, input logic [31:0] opb);
    start = 1'b1; mdop = op; a = opa; b = opb;
    tick();
    start = 1'b0; mdop = OP_NONE;
  endtask

  // Counts busy cycles (bounded) while checking HI/LO hold and no early done.
  task automatic run_busy(input string tag, output int n);
    logic [63:0] held;
    held = {hi, lo};
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      check({tag, "_hold"}, {hi, lo}, held);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int done_seen;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    // mult -3 * 5
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    run_busy("mult", n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_done", 64'(done), 64'd1);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    check("mult_done_pulse", 64'(done), 64'd0);

    // multu max * max
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy("multu", n);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    // back-to-back mult in the done cycle
    launch(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    run_busy("mult_min", n);
    check("mult_min_lat", 64'(n), 64'd5);
    check("mult_min_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // divu 100 / 7
    launch(OP_DIVU, 32'd100, 32'd7);
    run_busy("divu", n);
    check("divu_lat", 64'(n), 64'd33);
    check("divu_done", 64'(done), 64'd1);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    // back-to-back div -7 / 2
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy("div_neg", n);
    check("div_neg_lat", 64'(n), 64'd33);
    check("div_neg_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    check("div_done_pulse", 64'(done), 64'd0);

    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run_busy("div_negb", n);
    check("div_negb_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

    launch(OP_DIV, 32'h1234_5678, 32'd0);
    run_busy("div0", n);
    check("div0_lat", 64'(n), 64'd33);
    check("div0_hilo", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});

    launch(OP_DIVU, 32'd5, 32'd0);
    run_busy("divu0", n);
    check("divu0_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("div_ovf", n);
    check("div_ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

    // divu 1000 / 9 with an mthi attempt at cycle 10 that must be ignored
    launch(OP_DIVU, 32'd1000, 32'd9);
    repeat (8) tick();
    start = 1'b1; mdop = OP_MTHI; a = 32'h0000_DEAD;
    tick();
    start = 1'b0; mdop = OP_NONE;
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_hi", {hi, lo}, {32'd0, 32'h8000_0000});
    run_busy("ign", n);
    check("ign_lat_rest", 64'(n), 64'd24);
    check("ign_hilo", {hi, lo}, {32'd1, 32'd111});
    // mthi in the done cycle, then mtlo
    launch(OP_MTHI, 32'h0000_DEAD, 32'd0);
    check("mthi_hi", {hi, lo}, {32'h0000_DEAD, 32'd111});
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    launch(OP_MTLO, 32'h0000_0055, 32'd0);
    check("mtlo_lo", {hi, lo}, {32'h0000_DEAD, 32'h0000_0055});

    // reserved op is a no-op
    launch(4'hF, 32'h0000_0123, 32'd4);
    check("rsv_busy", 64'(busy), 64'd0);
    tick();
    check("rsv_hilo", {hi, lo}, {32'h0000_DEAD, 32'h0000_0055});

    // reset asserted mid-divide
    launch(OP_DIV, 32'd1000, 32'd3);
    repeat (11) tick();
    check("abort_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    // accumulate sequence
    launch(OP_MTHI, 32'd0, 32'd0);
    launch(OP_MTLO, 32'd10, 32'd0);
    launch(OP_MADDU, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
    run_busy("maddu", n);
    check("maddu_lat", 64'(n), 64'd5);
    check("maddu_hilo", {hi, lo}, {32'd0, 32'd22});
    launch(OP_MSUB, 32'd1, 32'd23);
    run_busy("msub", n);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("maddu_off_busy", 64'(busy), 64'd0);
    tick();
    check("maddu_off_hilo", {hi, lo}, {32'd0, 32'd10});
    launch(OP_MSUB, 32'd1, 32'd23);
    check("msub_off_busy", 64'(busy), 64'd0);
    tick();
    check("msub_off_hilo", {hi, lo}, {32'd0, 32'd10});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
